// File: rtl/adder32_arb_pkg.sv
// Shared types and constants for the adder32 round-robin arbiter.
// Included by the arbiter top and the adder datapath.
package adder32_arb_pkg;

   localparam int DATA_W  = 32;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } arb_state_t;

endpackage

// File: rtl/adder32.sv
// Shared 32-bit unsigned adder datapath with carry out of bit 31.
module adder32
   import adder32_arb_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum,
   output logic              carry_out
);

   assign {carry_out, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder32_arbiter.sv
// Round-robin arbiter sharing one adder32 among NUM_REQ requesters.
// Optional signed-overflow output enabled by defining ADDER32_ARB_OVF_EN.
module adder32_arbiter
   import adder32_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_sum,
   output logic                      rsp_carry
`ifdef ADDER32_ARB_OVF_EN
   ,
   output logic                      rsp_ovf
`endif
);

   arb_state_t state_reg;
   arb_state_t state_next;

   logic [ID_W-1:0]   last_gnt_reg;
   logic [ID_W-1:0]   id_reg;
   logic [DATA_W-1:0] op_a_reg;
   logic [DATA_W-1:0] op_b_reg;
   logic [ID_W-1:0]   rsp_id_reg;
   logic [DATA_W-1:0] rsp_sum_reg;
   logic              rsp_carry_reg;

   logic [DATA_W-1:0] a_lanes [NUM_REQ];
   logic [DATA_W-1:0] b_lanes [NUM_REQ];

   logic              any_valid;
   logic [ID_W-1:0]   winner;
   logic [ID_W:0]     cand_sum;
   logic [ID_W-1:0]   cand;
   logic [NUM_REQ-1:0] grant_onehot;

   logic [DATA_W-1:0] add_sum;
   logic              add_carry;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lanes
         assign a_lanes[gi] = req_a[gi*DATA_W +: DATA_W];
         assign b_lanes[gi] = req_b[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Scan from the farthest offset down so the nearest valid after last_gnt wins.
   always_comb begin
      any_valid = 1'b0;
      winner    = last_gnt_reg;
      cand_sum  = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand_sum = {1'b0, last_gnt_reg} + (ID_W+1)'(k);
         if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
            cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
         end
         cand = cand_sum[ID_W-1:0];
         if (req_valid[cand]) begin
            any_valid = 1'b1;
            winner    = cand;
         end
      end
   end

   assign grant_onehot = NUM_REQ'(1) << winner;

   adder32 u_adder32 (
      .a         (op_a_reg),
      .b         (op_b_reg),
      .sum       (add_sum),
      .carry_out (add_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (any_valid) state_next = ST_EXEC;
         ST_EXEC: state_next = ST_RESP;
         ST_RESP: if (rsp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Gating with rst_n keeps req_ready low while reset is held.
   always_comb begin
      req_ready = '0;
      rsp_valid = 1'b0;
      case (state_reg)
         ST_IDLE: if (any_valid && rst_n) req_ready = grant_onehot;
         ST_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_reg  <= ID_W'(NUM_REQ - 1);
         id_reg        <= '0;
         op_a_reg      <= '0;
         op_b_reg      <= '0;
         rsp_id_reg    <= '0;
         rsp_sum_reg   <= '0;
         rsp_carry_reg <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE && any_valid) begin
            op_a_reg     <= a_lanes[winner];
            op_b_reg     <= b_lanes[winner];
            id_reg       <= winner;
            last_gnt_reg <= winner;
         end
         if (state_reg == ST_EXEC) begin
            rsp_sum_reg   <= add_sum;
            rsp_carry_reg <= add_carry;
            rsp_id_reg    <= id_reg;
         end
      end
   end

`ifdef ADDER32_ARB_OVF_EN
   logic rsp_ovf_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_ovf_reg <= 1'b0;
      end else if (state_reg == ST_EXEC) begin
         rsp_ovf_reg <= (op_a_reg[DATA_W-1] == op_b_reg[DATA_W-1]) &&
                        (add_sum[DATA_W-1] != op_a_reg[DATA_W-1]);
      end
   end

   assign rsp_ovf = rsp_ovf_reg;
`endif

   assign rsp_id    = rsp_id_reg;
   assign rsp_sum   = rsp_sum_reg;
   assign rsp_carry = rsp_carry_reg;

endmodule

// File: tb/tb_adder32_arbiter.sv
// Self-checking bench for adder32_arbiter with a round-robin reference model.
// Overflow checks are compiled in when ADDER32_ARB_OVF_EN is defined.
module tb_adder32_arbiter;

   localparam int N    = 4;
   localparam int ID_W = 2;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*32-1:0]   req_a;
   logic [N*32-1:0]   req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [31:0]       rsp_sum;
   logic              rsp_carry;
`ifdef ADDER32_ARB_OVF_EN
   logic              rsp_ovf;
`endif

   logic [31:0] a_arr [N];
   logic [31:0] b_arr [N];

   int checks = 0;
   int errors = 0;
   int model_last = N - 1;

   adder32_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry)
`ifdef ADDER32_ARB_OVF_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < N; i++) begin
         req_a[i*32 +: 32] = a_arr[i];
         req_b[i*32 +: 32] = b_arr[i];
      end
   end

   // Round-robin rule: first valid requester after the previous winner.
   function automatic int rr_pick(input logic [N-1:0] mask);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (model_last + k) % N;
         if (mask[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] s;
      s = a + b;
      return (a[31] == b[31]) && (s[31] != a[31]);
   endfunction

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] one;
      one = 1;
      return (w < 0) ? '0 : (one << w);
   endfunction

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      rst_n      = 1'b1;
      model_last = N - 1;
   endtask

   // Drives one request, waits (bounded) for the response, then completes the handshake.
   task automatic run_txn(input logic [N-1:0] mask, input bit hold, input bit keep_rdy,
                          input int bp, output logic [N-1:0] rdy, output logic [ID_W-1:0] id,
                          output logic [31:0] sum, output logic carry, output logic ovf,
                          output int lat);
      req_valid = mask;
      rsp_ready = keep_rdy;
      #1;
      rdy = req_ready;
      @(posedge clk); #1;
      if (!hold) req_valid = '0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      id    = rsp_id;
      sum   = rsp_sum;
      carry = rsp_carry;
`ifdef ADDER32_ARB_OVF_EN
      ovf = rsp_ovf;
`else
      ovf = 1'b0;
`endif
      if (!keep_rdy) repeat (bp) begin
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = keep_rdy;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
         a_arr[i] = 32'h0;
         b_arr[i] = 32'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== 32'h0 || rsp_carry !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp: got v=%b id=%0d sum=%h c=%b expected all 0",
                  rsp_valid, rsp_id, rsp_sum, rsp_carry);
      end
`ifdef ADDER32_ARB_OVF_EN
      checks++;
      if (rsp_ovf !== 1'b0) begin
         errors++; $display("FAIL reset_ovf: got %b expected 0", rsp_ovf);
      end
`endif
      req_valid = '0;
      rst_n     = 1'b1;
      model_last = N - 1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [N-1:0] rdy; logic [ID_W-1:0] id; logic [31:0] sum; logic c, o; int lat;
      a_arr[0] = 32'h12345678;
      b_arr[0] = 32'h87654321;
      run_txn(4'b0001, 1'b0, 1'b0, 0, rdy, id, sum, c, o, lat);
      model_last = 0;
      $display("txn single id=%0d sum=%h carry=%b", id, sum, c);
      checks++;
      if (rdy !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", rdy); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", lat); end
      checks++;
      if (id !== 2'd0 || sum !== 32'h99999999 || c !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp: got id=%0d sum=%h c=%b expected id=0 sum=99999999 c=0", id, sum, c);
      end
   endtask

   task automatic test_carry();
      logic [N-1:0] rdy; logic [ID_W-1:0] id; logic [31:0] sum; logic c, o; int lat;
      a_arr[2] = 32'hFFFFFFFF;
      b_arr[2] = 32'h00000001;
      run_txn(4'b0100, 1'b0, 1'b0, 0, rdy, id, sum, c, o, lat);
      model_last = 2;
      $display("txn carry id=%0d sum=%h carry=%b", id, sum, c);
      checks++;
      if (id !== 2'd2 || sum !== 32'h0 || c !== 1'b1) begin
         errors++;
         $display("FAIL carry_wrap: got id=%0d sum=%h c=%b expected id=2 sum=00000000 c=1", id, sum, c);
      end
`ifdef ADDER32_ARB_OVF_EN
      a_arr[1] = 32'h7FFFFFFF;
      b_arr[1] = 32'h00000001;
      run_txn(4'b0010, 1'b0, 1'b0, 0, rdy, id, sum, c, o, lat);
      model_last = 1;
      $display("txn ovf_pos id=%0d sum=%h carry=%b ovf=%b", id, sum, c, o);
      checks++;
      if (id !== 2'd1 || sum !== 32'h80000000 || c !== 1'b0 || o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pos: got id=%0d sum=%h c=%b o=%b expected id=1 sum=80000000 c=0 o=1",
                  id, sum, c, o);
      end
      a_arr[3] = 32'h80000000;
      b_arr[3] = 32'h80000000;
      run_txn(4'b1000, 1'b0, 1'b0, 0, rdy, id, sum, c, o, lat);
      model_last = 3;
      $display("txn ovf_neg id=%0d sum=%h carry=%b ovf=%b", id, sum, c, o);
      checks++;
      if (id !== 2'd3 || sum !== 32'h0 || c !== 1'b1 || o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_neg: got id=%0d sum=%h c=%b o=%b expected id=3 sum=00000000 c=1 o=1",
                  id, sum, c, o);
      end
`endif
   endtask

   task automatic test_fairness();
      logic [N-1:0] rdy; logic [ID_W-1:0] id; logic [31:0] sum; logic c, o; int lat;
      logic [32:0] full;
      int w;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         a_arr[i] = $urandom;
         b_arr[i] = $urandom;
      end
      for (int t = 0; t < 8; t++) begin
         w = rr_pick(4'b1111);
         run_txn(4'b1111, 1'b1, 1'b1, 0, rdy, id, sum, c, o, lat);
         model_last = w;
         full = ref_add(a_arr[w], b_arr[w]);
         $display("txn fair t=%0d id=%0d sum=%h carry=%b", t, id, sum, c);
         checks++;
         if (int'(id) !== (t % N) || rdy !== onehot(t % N)) begin
            errors++;
            $display("FAIL fair_order: got id=%0d rdy=%b expected id=%0d", id, rdy, t % N);
         end
         checks++;
         if (sum !== full[31:0] || c !== full[32]) begin
            errors++;
            $display("FAIL fair_data: got sum=%h c=%b expected sum=%h c=%b", sum, c, full[31:0], full[32]);
         end
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back_backpressure();
      logic [N-1:0] rdy; logic [ID_W-1:0] id; logic [31:0] sum; logic c, o; int lat;
      logic [32:0] full;
      int w;
      bit bad;
      a_arr[0] = $urandom;
      b_arr[0] = $urandom;
      full = ref_add(a_arr[0], b_arr[0]);
      w = rr_pick(4'b0001);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== onehot(w)) begin
         errors++; $display("FAIL bp_accept: got %b expected %b", req_ready, onehot(w));
      end
      @(posedge clk); #1;
      model_last = w;
      req_valid = 4'b1110;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL bp_latency: got %0d expected 1", lat); end
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || int'(rsp_id) !== w || rsp_sum !== full[31:0] ||
             rsp_carry !== full[32] || req_ready !== '0) bad = 1'b1;
      end
      $display("txn backpressure id=%0d sum=%h carry=%b", rsp_id, rsp_sum, rsp_carry);
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bp_hold: got v=%b id=%0d sum=%h c=%b rdy=%b expected v=1 id=%0d sum=%h c=%b rdy=0000",
                  rsp_valid, rsp_id, rsp_sum, rsp_carry, req_ready, w, full[31:0], full[32]);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      w = rr_pick(4'b1110);
      checks++;
      if (req_ready !== onehot(w)) begin
         errors++; $display("FAIL bp_next_grant: got %b expected %b", req_ready, onehot(w));
      end
      a_arr[w] = $urandom;
      b_arr[w] = $urandom;
      full = ref_add(a_arr[w], b_arr[w]);
      run_txn(4'b1110, 1'b0, 1'b0, 0, rdy, id, sum, c, o, lat);
      model_last = w;
      $display("txn after_bp id=%0d sum=%h carry=%b", id, sum, c);
      checks++;
      if (int'(id) !== w || sum !== full[31:0] || c !== full[32]) begin
         errors++;
         $display("FAIL bp_after: got id=%0d sum=%h c=%b expected id=%0d sum=%h c=%b",
                  id, sum, c, w, full[31:0], full[32]);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] rdy; logic [ID_W-1:0] id; logic [31:0] sum; logic c, o; int lat;
      bit rose;
      a_arr[3] = 32'hDEADBEEF;
      b_arr[3] = 32'h11111111;
      a_arr[0] = 32'h00000005;
      b_arr[0] = 32'hFFFFFFFE;
      req_valid = 4'b1000;
      @(posedge clk); #1;
      req_valid = 4'b1001;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== 32'h0 || rsp_carry !== 1'b0 ||
          req_ready !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: got v=%b id=%0d sum=%h c=%b rdy=%b expected all 0",
                  rsp_valid, rsp_id, rsp_sum, rsp_carry, req_ready);
      end
      rose = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0) rose = 1'b1;
      end
      rst_n = 1'b1;
      model_last = N - 1;
      #1;
      if (rsp_valid !== 1'b0) rose = 1'b1;
      checks++;
      if (rose) begin errors++; $display("FAIL midrst_no_rsp: got rsp_valid=1 expected 0"); end
      run_txn(4'b1001, 1'b0, 1'b0, 0, rdy, id, sum, c, o, lat);
      model_last = 0;
      $display("txn after_reset id=%0d sum=%h carry=%b", id, sum, c);
      checks++;
      if (rdy !== 4'b0001 || id !== 2'd0 || sum !== 32'h00000003 || c !== 1'b1) begin
         errors++;
         $display("FAIL midrst_priority: got rdy=%b id=%0d sum=%h c=%b expected rdy=0001 id=0 sum=00000003 c=1",
                  rdy, id, sum, c);
      end
   endtask

   task automatic test_dropped();
      logic [N-1:0] rdy; logic [ID_W-1:0] id; logic [31:0] sum; logic c, o; int lat;
      int w;
      bit bad;
      bad = 1'b0;
      req_valid = 4'b0001;
      @(posedge clk); #1;
      model_last = 0;
      req_valid = '0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      req_valid = 4'b0010;
      #1;
      if (req_ready !== '0) bad = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      if (rsp_valid !== 1'b1) bad = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (req_ready !== '0) bad = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++; $display("FAIL drop_no_grant: got activity for dropped request 1 expected none");
      end
      w = rr_pick(4'b0110);
      a_arr[1] = 32'hCAFEF00D;
      b_arr[1] = 32'h01010101;
      run_txn(4'b0110, 1'b0, 1'b0, 0, rdy, id, sum, c, o, lat);
      model_last = w;
      $display("txn after_drop id=%0d sum=%h carry=%b", id, sum, c);
      checks++;
      if (w !== 1 || rdy !== 4'b0010 || id !== 2'd1 || sum !== 32'hCBFFF10E) begin
         errors++;
         $display("FAIL drop_last_gnt: got rdy=%b id=%0d sum=%h expected rdy=0010 id=1 sum=cbfff10e",
                  rdy, id, sum);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] rdy; logic [ID_W-1:0] id; logic [31:0] sum; logic c, o; int lat;
      logic [N-1:0] mask;
      logic [32:0] full;
      int w;
      for (int t = 0; t < 24; t++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0: a_arr[i] = 32'hFFFFFFFF;
               1: a_arr[i] = 32'h80000000;
               default: a_arr[i] = $urandom;
            endcase
            b_arr[i] = $urandom;
         end
         w = rr_pick(mask);
         full = ref_add(a_arr[w], b_arr[w]);
         run_txn(mask, 1'b0, 1'b0, $urandom_range(0, 3), rdy, id, sum, c, o, lat);
         model_last = w;
         $display("txn rand t=%0d mask=%b id=%0d sum=%h carry=%b", t, mask, id, sum, c);
         checks++;
         if (rdy !== onehot(w) || int'(id) !== w || lat !== 1) begin
            errors++;
            $display("FAIL rand_grant: got rdy=%b id=%0d lat=%0d expected rdy=%b id=%0d lat=1",
                     rdy, id, lat, onehot(w), w);
         end
         checks++;
         if (sum !== full[31:0] || c !== full[32]) begin
            errors++;
            $display("FAIL rand_data: got sum=%h c=%b expected sum=%h c=%b", sum, c, full[31:0], full[32]);
         end
`ifdef ADDER32_ARB_OVF_EN
         checks++;
         if (o !== ref_ovf(a_arr[w], b_arr[w])) begin
            errors++; $display("FAIL rand_ovf: got %b expected %b", o, ref_ovf(a_arr[w], b_arr[w]));
         end
`endif
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      req_valid = '0;
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      test_reset();
      test_single();
      test_carry();
      test_fairness();
      test_back_to_back_backpressure();
      test_reset_mid();
      test_dropped();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
